sram_rr_arbiter: RTL and testbench

//   Shares the single-port SRAM behind the AXI-to-SRAM adapter among NUM_REQ requesters
//   (adapter, DMA, debug, ...). Arbitration is round-robin; an optional per-requester lock

---
 rtl/sram_rr_arbiter.sv | 119 +++++++++++
 tb/tb_sram_rr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters.
// Supports a bounded grant lock and routes each 1-cycle read response back to its requester.
module sram_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 128,
    parameter int MAX_LOCK   = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [NUM_REQ-1:0]                we_i,
    input  logic [NUM_REQ-1:0]                lock_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     addr_i,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     wdata_i,
    output logic [NUM_REQ-1:0]                gnt_o,
    output logic [NUM_REQ-1:0]                rvalid_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              req_o,
    output logic                              we_o,
    output logic [ADDR_WIDTH-1:0]             addr_o,
    output logic [DATA_WIDTH/8-1:0]           be_o,
    output logic [DATA_WIDTH-1:0]             data_o,
    input  logic [DATA_WIDTH-1:0]             data_i
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam int BW = DATA_WIDTH / 8;
    localparam logic [CW-1:0] LOCK_LIM = CW'(MAX_LOCK - 1);

    logic [PW-1:0]      ptr_r;
    logic [PW-1:0]      own_r;
    logic               lock_vld_r;
    logic [CW-1:0]      lcnt_r;
    logic [NUM_REQ-1:0] rvalid_r;

    logic               gnt_vld_s;
    logic [PW-1:0]      gnt_idx_s;
    logic [PW-1:0]      cand_s;
    logic               hit_s;
    logic               sel_s;
    logic               lock_take_s;
    logic [PW-1:0]      ptr_nxt_s;

    // Lock owner wins while it keeps requesting; otherwise rotate from ptr_r (lowest offset wins).
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        cand_s    = '0;
        hit_s     = 1'b0;
        if (lock_vld_r && req_i[own_r]) begin
            gnt_vld_s = 1'b1;
            gnt_idx_s = own_r;
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                cand_s    = PW'((int'(ptr_r) + i) % NUM_REQ);
                hit_s     = req_i[cand_s];
                gnt_idx_s = hit_s ? cand_s : gnt_idx_s;
                gnt_vld_s = gnt_vld_s | hit_s;
            end
        end
    end

    assign sel_s       = gnt_vld_s & rst_ni;
    assign lock_take_s = lock_i[gnt_idx_s] && (lcnt_r < LOCK_LIM);
    assign ptr_nxt_s   = (gnt_idx_s == PW'(NUM_REQ - 1)) ? '0 : gnt_idx_s + PW'(1);

    // Route the granted requester onto the SRAM port; everything idles at zero otherwise.
    always_comb begin
        gnt_o  = '0;
        req_o  = 1'b0;
        we_o   = 1'b0;
        addr_o = '0;
        be_o   = '0;
        data_o = '0;
        if (sel_s) begin
            gnt_o[gnt_idx_s] = 1'b1;
            req_o            = 1'b1;
            we_o             = we_i[gnt_idx_s];
            addr_o           = addr_i[int'(gnt_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
            be_o             = be_i[int'(gnt_idx_s)*BW +: BW];
            data_o           = wdata_i[int'(gnt_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            req_o = 1'b0;
        end
    end

    // Priority pointer, lock bookkeeping and read-return tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_r      <= '0;
            own_r      <= '0;
            lock_vld_r <= 1'b0;
            lcnt_r     <= '0;
            rvalid_r   <= '0;
        end else begin
            rvalid_r <= gnt_o & ~we_i;
            if (gnt_vld_s) begin
                ptr_r <= ptr_nxt_s;
                if (lock_take_s) begin
                    lock_vld_r <= 1'b1;
                    own_r      <= gnt_idx_s;
                    lcnt_r     <= lcnt_r + CW'(1);
                end else begin
                    lock_vld_r <= 1'b0;
                    lcnt_r     <= '0;
                end
            end else begin
                lock_vld_r <= 1'b0;
                lcnt_r     <= '0;
            end
        end
    end

    assign rvalid_o = rvalid_r;
    assign rdata_o  = data_i;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Scoreboard bench for sram_rr_arbiter: directed scenarios plus random traffic,
// checked against a behavioural arbitration model and a reference memory.
module tb_sram_rr_arbiter;
    localparam int NR    = 4;
    localparam int AW    = 48;
    localparam int DW    = 128;
    localparam int ML    = 4;
    localparam int BW    = DW / 8;
    localparam int BOUND = (NR - 1) * ML + NR;

    logic               clk;
    logic               rst_ni;
    logic [NR-1:0]      req, we, lock;
    logic [NR*AW-1:0]   addr;
    logic [NR*BW-1:0]   be;
    logic [NR*DW-1:0]   wdata;
    logic [NR-1:0]      gnt, rvalid;
    logic [DW-1:0]      rdata;
    logic               sram_req, sram_we;
    logic [AW-1:0]      sram_addr;
    logic [BW-1:0]      sram_be;
    logic [DW-1:0]      sram_wdata, sram_rdata;

    sram_rr_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .lock_i(lock),
        .addr_i(addr), .be_i(be), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .req_o(sram_req), .we_o(sram_we), .addr_o(sram_addr),
        .be_o(sram_be), .data_o(sram_wdata), .data_i(sram_rdata)
    );

    typedef struct {
        int            cyc;
        logic [NR-1:0] gnt;
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } gexp_t;
    typedef struct {
        int            cyc;
        logic [NR-1:0] rv;
        logic [DW-1:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int m_ptr, m_own, m_lcnt, last_g;
    bit m_lock;
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] sram_mem [16];
    bit sram_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] dflt(input int i);
        return {4{32'hC0DE_0000 + 32'(i)}};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] b);
        logic [DW-1:0] res;
        res = old_w;
        for (int j = 0; j < BW; j++) if (b[j]) res[j*8 +: 8] = new_w[j*8 +: 8];
        return res;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Single-port SRAM with 1-cycle read latency, word index = addr[7:4].
    always @(posedge clk) begin
        if (!sram_ready) begin
            for (int i = 0; i < 16; i++) sram_mem[i] <= dflt(i);
            sram_ready <= 1'b1;
        end else if (sram_req) begin
            if (sram_we) sram_mem[sram_addr[7:4]] <= merge(sram_mem[sram_addr[7:4]], sram_wdata, sram_be);
            else         sram_rdata <= sram_mem[sram_addr[7:4]];
        end
    end

    // Reference arbitration: locked owner first, else first requester at or after the pointer.
    function automatic int model_pick();
        if (m_lock && req[m_own]) return m_own;
        for (int i = 0; i < NR; i++) if (req[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
        return -1;
    endfunction

    task automatic issue();
        gexp_t e;
        rexp_t r;
        int g, idx;
        g = model_pick();
        e.cyc = cyc; e.gnt = '0; e.we = 1'b0; e.addr = '0; e.be = '0; e.data = '0;
        if (g >= 0) begin
            e.gnt[g] = 1'b1;
            e.we     = we[g];
            e.addr   = addr[g*AW +: AW];
            e.be     = be[g*BW +: BW];
            e.data   = wdata[g*DW +: DW];
            idx = int'(e.addr[7:4]);
            if (e.we) ref_mem[idx] = merge(ref_mem[idx], e.data, e.be);
            else begin
                r.cyc = cyc + 1; r.rv = e.gnt; r.data = ref_mem[idx];
                rq.push_back(r);
            end
            m_ptr = (g + 1) % NR;
            if (lock[g] && m_lcnt < ML - 1) begin
                m_lock = 1'b1; m_own = g; m_lcnt++;
            end else begin
                m_lock = 1'b0; m_lcnt = 0;
            end
        end else begin
            m_lock = 1'b0; m_lcnt = 0;
        end
        gq.push_back(e);
        last_g = g;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_f(input int k, input bit w, input logic [AW-1:0] a, input logic [BW-1:0] b,
                         input logic [DW-1:0] d);
        we[k] = w;
        addr[k*AW +: AW] = a;
        be[k*BW +: BW] = b;
        wdata[k*DW +: DW] = d;
    endtask

    task automatic refresh(input int k);
        int p;
        p = (last_g == k && lock[k]) ? 90 : 55;
        req[k]  = ($urandom_range(0, 99) < p);
        lock[k] = ($urandom_range(0, 3) == 0);
        set_f(k, ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 15) * 16), BW'($urandom()),
              {$urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    task automatic do_reset(input int n);
        rst_ni = 1'b0;
        rq.delete(); gq.delete();
        m_ptr = 0; m_own = 0; m_lcnt = 0; m_lock = 1'b0; last_g = -1;
        #1;
        chk("rst_rvalid_now", DW'(rvalid), '0);
        repeat (n) begin
            #2;
            chk("rst_gnt", DW'(gnt), '0);
            chk("rst_req_o", DW'(sram_req), '0);
            chk("rst_rvalid", DW'(rvalid), '0);
            advance();
        end
        rst_ni = 1'b1;
    endtask

    // Monitor: pops expected grant/read entries and compares against what the DUT presents.
    initial begin
        gexp_t e;
        rexp_t r;
        int wait_c [NR];
        for (int k = 0; k < NR; k++) wait_c[k] = 0;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (gq.size() > 0 && gq[0].cyc == cyc) begin
                    e = gq.pop_front();
                    chk("gnt", DW'(gnt), DW'(e.gnt));
                    chk("req_o", DW'(sram_req), DW'(e.gnt != '0));
                    if (e.gnt != '0) begin
                        chk("we_o", DW'(sram_we), DW'(e.we));
                        chk("addr_o", DW'(sram_addr), DW'(e.addr));
                        chk("be_o", DW'(sram_be), DW'(e.be));
                        chk("data_o", sram_wdata, e.data);
                    end
                end
                if (rq.size() > 0 && rq[0].cyc == cyc) begin
                    r = rq.pop_front();
                    chk("rvalid", DW'(rvalid), DW'(r.rv));
                    chk("rdata", rdata, r.data);
                end else begin
                    chk("rvalid_idle", DW'(rvalid), '0);
                end
                chk("gnt_onehot0", DW'($onehot0(gnt)), DW'(1'b1));
                for (int k = 0; k < NR; k++) begin
                    if (gnt[k]) begin
                        chk("wait_bound", DW'(wait_c[k] <= BOUND), DW'(1'b1));
                        wait_c[k] = 0;
                    end else if (req[k]) begin
                        wait_c[k]++;
                        if (wait_c[k] == BOUND + 1) chk("starved", DW'(wait_c[k]), DW'(BOUND));
                    end else begin
                        wait_c[k] = 0;
                    end
                end
            end else begin
                for (int k = 0; k < NR; k++) wait_c[k] = 0;
            end
        end
    end

    initial begin
        logic [NR-1:0] exp1 [4];
        logic [NR-1:0] exp3 [6];
        logic [DW-1:0] dat_a;
        exp1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp3 = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010};
        dat_a = 128'hA5A5_0123_4567_89AB_CDEF_0011_2233_4455;
        for (int i = 0; i < 16; i++) ref_mem[i] = dflt(i);
        rst_ni = 1'b0;
        req = '1; we = '0; lock = '0; addr = '0; be = '0; wdata = '0;
        for (int k = 0; k < NR; k++) set_f(k, 1'b0, AW'(k * 16), '1, DW'(k));
        @(posedge clk);
        #1;
        do_reset(2);

        // Plain round robin over four readers.
        for (int i = 0; i < 4; i++) begin
            issue(); #3; chk("t1_gnt", DW'(gnt), DW'(exp1[i])); advance();
        end

        // Pointer positioning, wrap and idle hold.
        req = 4'b0010; issue(); #3; chk("t2_gnt_a", DW'(gnt), DW'(4'b0010)); advance();
        req = 4'b0101; issue(); #3; chk("t2_gnt_b", DW'(gnt), DW'(4'b0100)); advance();
        issue(); #3; chk("t2_gnt_c", DW'(gnt), DW'(4'b0001)); advance();
        req = 4'b0000; issue(); #3; chk("t2_idle", DW'(gnt), '0); advance();
        req = 4'b0101; issue(); #3; chk("t2_gnt_d", DW'(gnt), DW'(4'b0100)); advance();

        // Lock held for MAX_LOCK grants, then round robin resumes.
        req = 4'b0001; issue(); #3; chk("t3_pre", DW'(gnt), DW'(4'b0001)); advance();
        req = 4'b1010; lock = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            issue(); #3; chk("t3_gnt", DW'(gnt), DW'(exp3[i])); advance();
        end
        lock = '0;

        // Write by requester 2 then read-back by requester 0.
        req = 4'b0100; set_f(2, 1'b1, AW'(48'h40), 16'hFFFF, dat_a);
        issue(); #3; chk("t4_we_o", DW'(sram_we), DW'(1'b1)); advance();
        req = 4'b0001; set_f(0, 1'b0, AW'(48'h40), 16'hFFFF, '0);
        issue(); #3; chk("t4_no_wr_rvalid", DW'(rvalid), '0); advance();
        req = 4'b0000;
        issue(); #3; chk("t4_rvalid", DW'(rvalid), DW'(4'b0001)); chk("t4_rdata", rdata, dat_a); advance();

        // Reset right after a granted read drops the pending response.
        req = 4'b0001; issue(); advance();
        chk("t5_rvalid_pre", DW'(rvalid), DW'(4'b0001));
        req = 4'b1111;
        do_reset(1);
        issue(); #3; chk("t5_gnt_after", DW'(gnt), DW'(4'b0001)); advance();

        // Random traffic.
        for (int n = 0; n < 10000; n++) begin
            for (int k = 0; k < NR; k++) if (!req[k] || last_g == k) refresh(k);
            issue();
            advance();
        end

        req = '0;
        issue(); advance();
        issue(); advance();
        chk("drain_rq", DW'(rq.size()), '0);
        chk("drain_gq", DW'(gq.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
